// File: rtl/vec_line_fifo.sv
// Line-segment queue between the vector core and the line rasteriser.
// Circular buffer of DEPTH segments. The write event is either an edge or a level of
// wr_req. The read port is valid/ready, and the head entry is read combinationally.
module vec_line_fifo #(
  parameter int COORD_W  = 11,
  parameter int COLOR_W  = 3,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int EDGE_WR  = 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     flush,
  input  logic                     wr_req,
  input  logic [COORD_W-1:0]       wr_start_x,
  input  logic [COORD_W-1:0]       wr_start_y,
  input  logic [COORD_W-1:0]       wr_end_x,
  input  logic [COORD_W-1:0]       wr_end_y,
  input  logic [COLOR_W-1:0]       wr_color,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [COORD_W-1:0]       rd_start_x,
  output logic [COORD_W-1:0]       rd_start_y,
  output logic [COORD_W-1:0]       rd_end_x,
  output logic [COORD_W-1:0]       rd_end_y,
  output logic [COLOR_W-1:0]       rd_color,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * COORD_W + COLOR_W;

  logic          wr_req_q_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic          wr_ev;
  logic          pop;
  logic          push;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;
  logic [EW-1:0] entry_q [DEPTH];

  assign wr_data     = {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_color};
  assign wr_ev       = (EDGE_WR != 0) ? (wr_req & ~wr_req_q_reg) : wr_req;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == CW'(DEPTH));
  assign almost_full = (count_reg >= CW'(AF_LEVEL));
  assign rd_valid    = ~empty;
  assign count       = count_reg;
  assign overflow    = overflow_reg;

  // A pop frees the slot the same cycle, so a write into a full queue is still accepted.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_ev & (~full | pop);

  // The edge detector keeps sampling through a flush, so a held request does not re-fire.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_req_q_reg <= 1'b0;
    end else begin
      wr_req_q_reg <= wr_req;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // A dropped write wins over a same-cycle clear, so the loss is never hidden.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      overflow_reg <= 1'b0;
    end else if (flush) begin
      overflow_reg <= 1'b0;
    end else if (wr_ev && full && !pop) begin
      overflow_reg <= 1'b1;
    end else if (clear_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;

      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          entry_reg <= '0;
        end else if (push && !flush && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = entry_q[rd_ptr_reg];
  assign {rd_start_x, rd_start_y, rd_end_x, rd_end_y, rd_color} = rd_data;

endmodule
